// File: rtl/mem_pkg.sv
// Shared constants, FSM state encoding and byte-lane decode for the data-memory responder.
package mem_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t ST_IDLE = 2'd0;
    localparam mem_state_t ST_WAIT = 2'd1;
    localparam mem_state_t ST_RESP = 2'd2;

    typedef struct packed {
        logic [3:0] be;
        logic       misalign;
    } mem_lane_t;

    // Reserved size yields no lanes; the caller flags it as a fault separately.
    function automatic mem_lane_t mem_lanes(input logic [1:0] size, input logic [1:0] off);
        mem_lane_t r;
        r.be       = 4'b0000;
        r.misalign = 1'b0;
        case (size)
            MEM_SIZE_B: r.be = 4'b0001 << off;
            MEM_SIZE_H: begin
                r.be       = 4'b0011 << off;
                r.misalign = off[0];
            end
            MEM_SIZE_W: begin
                r.be       = 4'b1111;
                r.misalign = (off != 2'd0);
            end
            default: r.be = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_data_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module mem_data_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_data.sv
// Data-memory responder: one request in, one response out, at most one in flight.
// Optional extra response latency is enabled with the MEM_DATA_WAIT_EN macro.
//
// state   | meaning
// IDLE    | no response pending, ready for a request
// WAIT    | access done, counting down extra latency (MEM_DATA_WAIT_EN only)
// RESP    | response presented, held until the core takes it
module mem_data
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    if ((DEPTH_WORDS < 4) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) ||
        ((BASE_ADDR & (SPAN - 32'd1)) != 32'd0) ||
        (WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_param
        $error("mem_data: illegal parameter combination");
    end

`ifdef MEM_DATA_WAIT_EN
    localparam mem_state_t ST_AFTER_ACCEPT = ST_WAIT;
    logic [3:0] cnt_q, cnt_d;
`else
    localparam mem_state_t ST_AFTER_ACCEPT = ST_RESP;
`endif

    mem_state_t  state_q, state_d;
    logic        err_q, err_d;
    logic        ld_q, ld_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;

    logic        accept;
    logic [31:0] offset;
    mem_lane_t   lanes;
    logic        fault;
    logic        ram_we, ram_re;
    logic [31:0] ram_wdata, ram_rdata, shifted;

    assign req_ready_o = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    // Unsigned subtract: addresses below BASE_ADDR wrap high and land out of range.
    assign offset = req_addr_i - BASE_ADDR;
    assign lanes  = mem_lanes(req_size_i, req_addr_i[1:0]);
    assign fault  = (req_size_i == 2'd3) || lanes.misalign || (offset >= SPAN);
    assign ram_we = accept && req_we_i && !fault;
    assign ram_re = accept && !req_we_i && !fault;

    always_comb begin
        case (req_size_i)
            MEM_SIZE_B: ram_wdata = {4{req_wdata_i[7:0]}};
            MEM_SIZE_H: ram_wdata = {2{req_wdata_i[15:0]}};
            default:    ram_wdata = req_wdata_i;
        endcase
    end

    mem_data_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .be_i    (lanes.be),
        .re_i    (ram_re),
        .addr_i  (offset[AW+1:2]),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        ld_d    = ld_q;
        off_d   = off_q;
        size_d  = size_q;
`ifdef MEM_DATA_WAIT_EN
        cnt_d   = cnt_q;
`endif
        if (accept) begin
            err_d  = fault;
            ld_d   = ram_re;
            off_d  = req_addr_i[1:0];
            size_d = req_size_i;
        end
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_AFTER_ACCEPT;
`ifdef MEM_DATA_WAIT_EN
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) state_d = ST_RESP;
            end
`endif
            ST_RESP: if (rsp_ready_i) state_d = accept ? ST_AFTER_ACCEPT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef MEM_DATA_WAIT_EN
        if (accept) cnt_d = 4'(WAIT_CYCLES);
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
            off_q   <= 2'd0;
            size_q  <= 2'd0;
`ifdef MEM_DATA_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
            off_q   <= off_d;
            size_q  <= size_d;
`ifdef MEM_DATA_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign shifted     = ram_rdata >> {off_q, 3'b000};
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_err_o   = rsp_valid_o && err_q;

    always_comb begin
        rsp_rdata_o = 32'd0;
        if (rsp_valid_o && ld_q) begin
            case (size_q)
                MEM_SIZE_B: rsp_rdata_o = {24'd0, shifted[7:0]};
                MEM_SIZE_H: rsp_rdata_o = {16'd0, shifted[15:0]};
                default:    rsp_rdata_o = shifted;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_data.sv
// Directed testbench for mem_data: vector table plus stall, streaming and reset sequences.
module tb_mem_data;
    import mem_pkg::*;

    localparam int WAITC = 3;
`ifdef MEM_DATA_WAIT_EN
    localparam int LAT_EXP = 1 + WAITC;
`else
    localparam int LAT_EXP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_data #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0001_0000), .WAIT_CYCLES(WAITC)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_size_i  (req_size),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
    endtask

    // Call at a negedge just after the accept edge; returns cycles until rsp_valid.
    task automatic wait_rsp(output int lat, input logic chk_ready_low);
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            if (chk_ready_low) chk("ready_low_while_pending", 32'(req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
        int guard;
        @(negedge clk);
        drive(we, addr, size, wdata);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat, 1'b0);
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] exp_prev;

        vecs[0]  = '{1'b1, 32'h0001_0004, MEM_SIZE_W, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0001_0004, MEM_SIZE_W, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0001_0005, MEM_SIZE_B, 32'h0000_005A, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h0001_0004, MEM_SIZE_W, 32'h0,         32'hDEAD_5AEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h0001_0006, MEM_SIZE_H, 32'h0,         32'h0000_DEAD, 1'b0};
        vecs[5]  = '{1'b0, 32'h0001_0005, MEM_SIZE_B, 32'h0,         32'h0000_005A, 1'b0};
        vecs[6]  = '{1'b1, 32'h0001_0000, MEM_SIZE_W, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b0, 32'h0001_0002, MEM_SIZE_W, 32'h0,         32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 32'h0001_0001, MEM_SIZE_H, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 32'h0001_0000, 2'd3,       32'h0,         32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 32'h0000_FFFC, MEM_SIZE_W, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b0, 32'h0001_0000, MEM_SIZE_W, 32'h0,         32'h1122_3344, 1'b0};
        vecs[12] = '{1'b0, 32'h0001_1000, MEM_SIZE_W, 32'h0,         32'h0000_0000, 1'b1};
        vecs[13] = '{1'b1, 32'h0001_0FFC, MEM_SIZE_W, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b1, 32'h0001_0FFE, MEM_SIZE_H, 32'h0000_ABCD, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, 32'h0001_0FFC, MEM_SIZE_W, 32'h0,         32'hABCD_0000, 1'b0};
        vecs[16] = '{1'b1, 32'h0001_0003, MEM_SIZE_B, 32'h0000_0077, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 32'h0001_0000, MEM_SIZE_W, 32'h0,         32'h7722_3344, 1'b0};
        vecs[18] = '{1'b0, 32'h0001_0002, MEM_SIZE_H, 32'h0,         32'h0000_7722, 1'b0};
        vecs[19] = '{1'b0, 32'h0001_0003, MEM_SIZE_B, 32'h0,         32'h0000_0077, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_ready", 32'(req_ready), 32'd1);

        // Vector table
        for (int i = 0; i < 20; i++) begin
            xact(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT_EXP));
        end

        // Response stall with a second request waiting
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1'b0, 32'h0001_0004, MEM_SIZE_W, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 32'h0001_0006, MEM_SIZE_H, 32'h0);
        wait_rsp(lat, 1'b1);
        chk("stall_first_rdata", rsp_rdata, 32'hDEAD_5AEF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d_rdata", k), rsp_rdata, 32'hDEAD_5AEF);
        end
        rsp_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat, 1'b0);
        chk("stall_second_latency", 32'(lat), 32'(LAT_EXP));
        chk("stall_second_rdata", rsp_rdata, 32'h0000_DEAD);

`ifndef MEM_DATA_WAIT_EN
        // Back-to-back store/load pairs, one response per cycle
        exp_prev = 32'd0;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("stream%0d_valid", i - 1), 32'(rsp_valid), 32'd1);
                chk($sformatf("stream%0d_rdata", i - 1), rsp_rdata, exp_prev);
            end
            chk($sformatf("stream%0d_ready", i), 32'(req_ready), 32'd1);
            d = 32'hA5C3_0000 | 32'((i / 2) * 32'h0000_0101);
            if (i % 2 == 0) begin
                drive(1'b1, 32'h0001_0008, MEM_SIZE_W, d);
                exp_prev = 32'd0;
            end else begin
                drive(1'b0, 32'h0001_0008, MEM_SIZE_W, 32'h0);
                exp_prev = d;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("stream15_valid", 32'(rsp_valid), 32'd1);
        chk("stream15_rdata", rsp_rdata, exp_prev);
`else
        // Ready must stay low throughout the wait window
        @(negedge clk);
        drive(1'b0, 32'h0001_0000, MEM_SIZE_W, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat, 1'b1);
        chk("wait_latency", 32'(lat), 32'(LAT_EXP));
        chk("wait_rdata", rsp_rdata, 32'h7722_3344);

        // Reset while in WAIT
        @(negedge clk);
        drive(1'b0, 32'h0001_0000, MEM_SIZE_W, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait_rst_pre_valid", 32'(rsp_valid), 32'd0);
        chk("wait_rst_pre_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("wait_rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("wait_rst_idle_ready", 32'(req_ready), 32'd1);
        repeat (WAITC + 2) @(negedge clk);
        chk("wait_rst_no_ghost_rsp", 32'(rsp_valid), 32'd0);
`endif

        // Reset with a store response pending: response dropped, store kept
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1'b1, 32'h0001_000C, MEM_SIZE_W, 32'hCAFE_F00D);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat, 1'b0);
        chk("rstmid_pre_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_rdata", rsp_rdata, 32'd0);
        chk("rstmid_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("rstmid_idle_ready", 32'(req_ready), 32'd1);
        xact(1'b0, 32'h0001_000C, MEM_SIZE_W, 32'h0, rd, er, lat);
        chk("rstmid_store_kept", rd, 32'hCAFE_F00D);
        chk("rstmid_load_err", 32'(er), 32'd0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_data.md
Name: mem_data

Overview:
Data-memory responder for the core's load/store path. It supplies the memory source for the register-writeback mux and closes the responder end of the data-access interface. The core issues valid/ready requests (address, size, write data); this block answers each request with one response carrying read data or an error. It is single-port synchronous RAM with byte-lane writes and at most one response in flight.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
BASE_ADDR, 32'h0001_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
WAIT_CYCLES, 2, extra response latency in cycles; range 1..15; used only with MEM_DATA_WAIT_EN.

Ports:
clk_i  in  1  clock; all logic on posedge.
rst_i  in  1  asynchronous, active-high reset.
req_valid_i  in  1  request present.
req_ready_o  out  1  request can be accepted this cycle.
req_we_i  in  1  1 = store, 0 = load.
req_addr_i  in  32  byte address.
req_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
req_wdata_i  in  32  store data, right-justified.
rsp_valid_o  out  1  response present.
rsp_ready_i  in  1  core accepts the response.
rsp_rdata_o  out  32  load data, right-justified and zero-extended; the core sign-extends.
rsp_err_o  out  1  the access faulted.

Behaviour:
- Reset (async, rst_i=1): rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, FSM=IDLE. req_ready_o=1 once rst_i deasserts. RAM contents are not reset.
- Accept: a request is accepted on a posedge when req_valid_i && req_ready_o.
- Ready rule: req_ready_o = (FSM==IDLE) || (FSM==RESP && rsp_ready_i). This allows back-to-back requests with no bubble. req_ready_o is 0 in WAIT.
- FSM states: IDLE, WAIT, RESP.
  - IDLE + accept -> RESP (or WAIT when the wait feature is enabled).
  - RESP + rsp_ready_i + new accept -> RESP with the new response.
  - RESP + rsp_ready_i + no accept -> IDLE.
  - RESP + !rsp_ready_i -> stays in RESP; rdata and err held stable.
- Latency: the response is valid in the cycle after the accept edge (1 cycle).
- Fault: rsp_err_o=1 when any of the following holds:
  - size==3;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - (addr - BASE_ADDR) >= DEPTH_WORDS*4, computed as an unsigned 32-bit subtract, so addresses below BASE_ADDR wrap and fault.
  - On a fault: no RAM write and rdata=0.
- Store: the write is committed at the accept edge.
  - Byte lanes: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0].
  - Data is replicated into the lanes: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}.
  - The response carries rdata=0, err=0.
- Load: the selected word is shifted right by 8*addr[1:0] and masked to the access size.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the new data; no stale read.
- Reset mid-operation: a pending response is dropped and a store already committed stays in RAM.
- rsp_valid_o is driven only from registers; no combinational path from req_* to rsp_*.

Optional Feature:
MEM_DATA_WAIT_EN.
- Defined: after accept the FSM enters WAIT and a 4-bit counter loads WAIT_CYCLES and decrements each cycle; at 0 the FSM moves to RESP. Total latency = 1 + WAIT_CYCLES. The RAM write still happens at the accept edge. This mode exercises core stalls.
- Undefined: the WAIT state and the counter are absent and latency is fixed at 1.

Decomposition:
- Package mem_pkg:
  - size constants MEM_SIZE_B=2'd0, MEM_SIZE_H=2'd1, MEM_SIZE_W=2'd2;
  - FSM state typedef (IDLE/WAIT/RESP);
  - the function computing byte-enable and the misalignment flag from size and addr[1:0].
- Sub-module mem_data_ram: DEPTH_WORDS x 32 array with 4-bit byte-enable write and registered read.
- mem_data holds the FSM, decode, fault logic and response formatting.

Test Plan:
1. Reset, then store word 0xDEADBEEF at 0x0001_0004, then load word 0x0001_0004 -> each response arrives 1 cycle after accept; the load returns 0xDEADBEEF with err=0.
2. Store byte 0x5A at 0x0001_0005 over 0xDEADBEEF, then load word -> 0xDEAD5AEF. Load half at 0x0001_0006 -> 0x0000DEAD.
3. Load word at 0x0001_0002, store half at 0x0001_0001, size=3, and address 0x0000_FFFC -> all return err=1 and rdata=0; a following load of 0x0001_0000 shows the RAM unchanged.
4. Hold rsp_ready_i=0 for 3 cycles with a second request pending -> req_ready_o=0 and rsp_rdata_o stays stable. Raise rsp_ready_i -> the second request is accepted in the same cycle and the next response follows with no bubble.
5. 8 back-to-back alternating store/load pairs to the same word with rsp_ready_i=1 -> one response per cycle and each load returns the preceding store's data.
6. With MEM_DATA_WAIT_EN and WAIT_CYCLES=3, issue a load -> rsp_valid_o rises 4 cycles after accept and req_ready_o is low in between. Assert rst_i during WAIT -> rsp_valid_o=0 immediately and the FSM is in IDLE after release.
